if_fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues requests to instruction memory over a req/gnt/rvalid bus, with one request outstanding at most.
- Presents a registered {address, instruction, valid} triple to IF/ID.
- Honours the pipeline hold vector and redirects on jump/branch from EX, discarding stale fetches.

---
 rtl/if_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC and keeps at most one request outstanding on the req/gnt/rvalid
// instruction bus. It presents a registered {addr, data, valid} entry and
// uses a one-entry skid buffer to absorb a response that lands during a hold.
// EX redirects flush the entry and the skid, and a kill flag discards the
// stale response that is still in flight.
module if_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        flag_jump,
  input  logic [31:0] jump_addr,
  input  logic [2:0]  flag_hold,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        inst_valid_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_data_o
);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] pend_addr_r, pend_addr_nxt_s;
  logic        kill_r, kill_nxt_s;
  logic        skid_valid_r, skid_valid_nxt_s;
  logic [31:0] skid_addr_r, skid_addr_nxt_s;
  logic [31:0] skid_data_r, skid_data_nxt_s;
  logic        out_valid_r, out_valid_nxt_s;
  logic [31:0] out_addr_r, out_addr_nxt_s;
  logic [31:0] out_data_r, out_data_nxt_s;
  logic        hold_s;
  logic        req_s;
  logic        take_s;

  assign ibus_req     = req_s;
  assign ibus_addr    = pc_r;
  assign inst_valid_o = out_valid_r;
  assign inst_addr_o  = out_addr_r;
  assign inst_data_o  = out_data_r;

  // Request gating: no fetch in reset or redirect cycles. No fetch while the
  // skid is occupied or a held entry is waiting, so a response always has room.
  always_comb begin
    hold_s = (flag_hold != 3'b000);
    if ((state_r == S_REQ) && !sys_rst && !flag_jump && !skid_valid_r &&
        !(hold_s && out_valid_r)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Next-state logic: bus FSM, PC, kill flag, output entry and skid buffer.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    pend_addr_nxt_s  = pend_addr_r;
    kill_nxt_s       = kill_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_addr_nxt_s  = skid_addr_r;
    skid_data_nxt_s  = skid_data_r;
    out_valid_nxt_s  = out_valid_r;
    out_addr_nxt_s   = out_addr_r;
    out_data_nxt_s   = out_data_r;
    take_s           = 1'b0;

    case (state_r)
      S_REQ: begin
        // A stale response after reset can only show up here; it is ignored.
        kill_nxt_s = 1'b0;
        if (req_s && ibus_gnt) begin
          pend_addr_nxt_s = pc_r;
          pc_nxt_s        = pc_r + 32'd4;
          state_nxt_s     = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid) begin
          state_nxt_s = S_REQ;
          kill_nxt_s  = 1'b0;
          take_s      = !kill_r;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: begin
        state_nxt_s = S_REQ;
        kill_nxt_s  = 1'b0;
      end
    endcase

    if (flag_jump) begin
      // A redirect beats hold and any response arriving in the same cycle.
      pc_nxt_s         = jump_addr & ~32'h0000_0003;
      out_valid_nxt_s  = 1'b0;
      out_data_nxt_s   = NOP;
      skid_valid_nxt_s = 1'b0;
      take_s           = 1'b0;
      if ((state_r == S_WAIT) && !ibus_rvalid) begin
        kill_nxt_s = 1'b1;
      end else begin
        kill_nxt_s = 1'b0;
      end
    end else if (!hold_s) begin
      // The downstream stage takes the entry; refill it, oldest source first.
      if (skid_valid_r) begin
        out_valid_nxt_s  = 1'b1;
        out_addr_nxt_s   = skid_addr_r;
        out_data_nxt_s   = skid_data_r;
        skid_valid_nxt_s = 1'b0;
      end else if (take_s) begin
        out_valid_nxt_s = 1'b1;
        out_addr_nxt_s  = pend_addr_r;
        out_data_nxt_s  = ibus_rdata;
      end else begin
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = NOP;
      end
    end else begin
      // Held: the entry is frozen, and a response is parked in the skid.
      if (take_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_addr_nxt_s  = pend_addr_r;
        skid_data_nxt_s  = ibus_rdata;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end
  end

  // State registers. A reset taken mid-fetch arms kill for the abandoned reply.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_ADDR;
      pend_addr_r  <= 32'h0000_0000;
      kill_r       <= (state_r == S_WAIT);
      skid_valid_r <= 1'b0;
      skid_addr_r  <= 32'h0000_0000;
      skid_data_r  <= 32'h0000_0000;
      out_valid_r  <= 1'b0;
      out_addr_r   <= 32'h0000_0000;
      out_data_r   <= NOP;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pend_addr_r  <= pend_addr_nxt_s;
      kill_r       <= kill_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_addr_r  <= skid_addr_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      out_addr_r   <= out_addr_nxt_s;
      out_data_r   <= out_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus a randomized run. The randomized
// run is checked against a stream model: fetches and presented entries must
// each be strictly sequential from the last redirect, and every presented
// word must match the memory image.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        sys_clk;
  logic        sys_rst;
  logic        flag_jump;
  logic [31:0] jump_addr;
  logic [2:0]  flag_hold;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        inst_valid_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_o;

  int errors = 0;
  int checks = 0;

  if_fetch_unit dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .flag_jump   (flag_jump),
    .jump_addr   (jump_addr),
    .flag_hold   (flag_hold),
    .ibus_req    (ibus_req),
    .ibus_addr   (ibus_addr),
    .ibus_gnt    (ibus_gnt),
    .ibus_rvalid (ibus_rvalid),
    .ibus_rdata  (ibus_rdata),
    .inst_valid_o(inst_valid_o),
    .inst_addr_o (inst_addr_o),
    .inst_data_o (inst_data_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Memory image: address 0 holds 0x00500093.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_jump   = 1'b0;
    jump_addr   = 32'h0;
    flag_hold   = 3'b000;
    ibus_gnt    = 1'b0;
    ibus_rvalid = 1'b0;
    ibus_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    #1;
  endtask

  // One fetch with a one-cycle memory: grant now, data on the next cycle.
  task automatic serve(input logic [31:0] a);
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt    = 1'b0;
    ibus_rvalid = 1'b1;
    ibus_rdata  = memval(a);
    tick();
    ibus_rvalid = 1'b0;
    ibus_rdata  = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst = 1'b1;
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
    checks++; if (inst_data_o !== NOP) begin errors++; $display("FAIL rst_data: got %h want %h", inst_data_o, NOP); end
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", ibus_req); end
    sys_rst = 1'b0;
    #1;
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin errors++; $display("FAIL first_req: req %b addr %h want 1 0", ibus_req, ibus_addr); end
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h0050_0093;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b want 0", ibus_req); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", inst_valid_o); end
    tick();
    ibus_rvalid = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_data_o !== 32'h0050_0093) begin
      errors++; $display("FAIL first_inst: got %b %h %h want 1 0 00500093", inst_valid_o, inst_addr_o, inst_data_o); end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h4) begin errors++; $display("FAIL second_req: req %b addr %h want 1 4", ibus_req, ibus_addr); end
  endtask

  task automatic test_hold();
    do_reset();
    serve(32'h0);
    serve(32'h4);
    // Entry 4 presented: a hold freezes it and blocks fetching.
    flag_hold = 3'b010;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL hold_blocks_req: got %b want 0", ibus_req); end
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h4 || inst_data_o !== memval(32'h4)) begin
      errors++; $display("FAIL hold_keeps: got %b %h %h want 1 4 %h", inst_valid_o, inst_addr_o, inst_data_o, memval(32'h4)); end
    // Release: entry 4 consumed while fetch 8 is granted.
    flag_hold = 3'b000; ibus_gnt = 1'b1;
    tick();
    // Hold while 8 is outstanding and its data returns.
    ibus_gnt = 1'b0; flag_hold = 3'b010; ibus_rvalid = 1'b1; ibus_rdata = memval(32'h8);
    tick();
    ibus_rvalid = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || ibus_req !== 1'b0) begin errors++; $display("FAIL skid_held: valid %b req %b want 0 0", inst_valid_o, ibus_req); end
    tick();
    flag_hold = 3'b000;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL skid_drain_req: got %b want 0", ibus_req); end
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_data_o !== memval(32'h8)) begin
      errors++; $display("FAIL skid_out: got %b %h %h want 1 8 %h", inst_valid_o, inst_addr_o, inst_data_o, memval(32'h8)); end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hC) begin errors++; $display("FAIL after_skid_req: req %b addr %h want 1 c", ibus_req, ibus_addr); end
  endtask

  task automatic test_jump_wait();
    do_reset();
    flag_jump = 1'b1; jump_addr = 32'h10;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL jump_cycle_req: got %b want 0", ibus_req); end
    tick();
    flag_jump = 1'b0;
    #1;
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h10) begin errors++; $display("FAIL jump_target_req: req %b addr %h want 1 10", ibus_req, ibus_addr); end
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt = 1'b0; flag_jump = 1'b1; jump_addr = 32'h103;
    tick();
    flag_jump = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = memval(32'h10);
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL kill_wait_req: got %b want 0", ibus_req); end
    tick();
    ibus_rvalid = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || inst_data_o !== NOP) begin errors++; $display("FAIL stale_dropped: got %b %h want 0 %h", inst_valid_o, inst_data_o, NOP); end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h100) begin errors++; $display("FAIL redirect_req: req %b addr %h want 1 100", ibus_req, ibus_addr); end
    serve(32'h100);
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_data_o !== memval(32'h100)) begin
      errors++; $display("FAIL redirect_inst: got %b %h %h want 1 100 %h", inst_valid_o, inst_addr_o, inst_data_o, memval(32'h100)); end
  endtask

  task automatic test_jump_rvalid_hold();
    do_reset();
    serve(32'h0);
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = memval(32'h4);
    flag_hold = 3'b100; flag_jump = 1'b1; jump_addr = 32'h200;
    tick();
    ibus_rvalid = 1'b0; flag_jump = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || inst_data_o !== NOP) begin errors++; $display("FAIL jr_out_clear: got %b %h want 0 %h", inst_valid_o, inst_data_o, NOP); end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin errors++; $display("FAIL jr_target: req %b addr %h want 1 200", ibus_req, ibus_addr); end
    // Fill the skid under hold, then redirect: the skid must be flushed.
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = memval(32'h200);
    tick();
    ibus_rvalid = 1'b0; flag_hold = 3'b000; flag_jump = 1'b1; jump_addr = 32'h300;
    tick();
    flag_jump = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || ibus_req !== 1'b1 || ibus_addr !== 32'h300) begin
      errors++; $display("FAIL skid_flush: valid %b req %b addr %h want 0 1 300", inst_valid_o, ibus_req, ibus_addr); end
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL skid_flush_late: got %b want 0", inst_valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    flag_jump = 1'b1; jump_addr = 32'hFFFF_FFFF;
    tick();
    flag_jump = 1'b0;
    #1;
    checks++; if (ibus_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", ibus_addr); end
    serve(32'hFFFF_FFFC);
    checks++; if (inst_addr_o !== 32'hFFFF_FFFC || inst_data_o !== memval(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_inst: got %h %h want fffffffc %h", inst_addr_o, inst_data_o, memval(32'hFFFF_FFFC)); end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: req %b addr %h want 1 0", ibus_req, ibus_addr); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    serve(32'h0);
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt = 1'b0; sys_rst = 1'b1;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL rw_rst_req: got %b want 0", ibus_req); end
    tick();
    sys_rst = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = memval(32'h4);
    #1;
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin errors++; $display("FAIL rw_refetch: req %b addr %h want 1 0", ibus_req, ibus_addr); end
    tick();
    ibus_rvalid = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || inst_data_o !== NOP) begin errors++; $display("FAIL rw_ignored: got %b %h want 0 %h", inst_valid_o, inst_data_o, NOP); end
    serve(32'h0);
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_data_o !== memval(32'h0)) begin
      errors++; $display("FAIL rw_inst: got %b %h %h want 1 0 %h", inst_valid_o, inst_addr_o, inst_data_o, memval(32'h0)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_fetch, exp_present, target, pend_addr;
    logic        pend;
    int          cd, consumed;
    do_reset();
    exp_fetch = 32'h0; exp_present = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; cd = 0; consumed = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      flag_jump = ($urandom_range(0, 15) == 0);
      target = $urandom;
      if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      jump_addr   = target;
      flag_hold   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      ibus_gnt    = ($urandom_range(0, 2) != 0);
      ibus_rvalid = pend && (cd == 0);
      ibus_rdata  = ibus_rvalid ? memval(pend_addr) : $urandom;
      #1;
      if (inst_valid_o !== 1'b1) begin
        checks++; if (inst_data_o !== NOP) begin errors++; $display("FAIL rnd_nop: cyc %0d got %h want %h", cyc, inst_data_o, NOP); end
      end
      if (flag_jump) begin
        checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL rnd_jump_req: cyc %0d got %b want 0", cyc, ibus_req); end
      end
      if (ibus_req && ibus_gnt) begin
        checks++; if (pend || ibus_rvalid) begin errors++; $display("FAIL rnd_outstanding: cyc %0d got 2 want 1", cyc); end
        checks++; if (ibus_addr !== exp_fetch) begin errors++; $display("FAIL rnd_fetch_addr: cyc %0d got %h want %h", cyc, ibus_addr, exp_fetch); end
        exp_fetch = exp_fetch + 32'd4;
      end
      if (!flag_jump && flag_hold == 3'b000 && inst_valid_o === 1'b1) begin
        checks++; if (inst_addr_o !== exp_present || inst_data_o !== memval(exp_present)) begin
          errors++; $display("FAIL rnd_stream: cyc %0d got %h %h want %h %h", cyc, inst_addr_o, inst_data_o, exp_present, memval(exp_present)); end
        exp_present = exp_present + 32'd4;
        consumed++;
      end
      if (flag_jump) begin
        exp_fetch   = target & ~32'h3;
        exp_present = target & ~32'h3;
      end
      if (ibus_rvalid) pend = 1'b0;
      else if (pend) cd--;
      if (ibus_req && ibus_gnt) begin
        pend = 1'b1; pend_addr = ibus_addr; cd = $urandom_range(0, 2);
      end
      tick();
    end
    idle_inputs();
    checks++; if (consumed < 200) begin errors++; $display("FAIL rnd_progress: got %0d want >=200", consumed); end
  endtask

  initial begin
    sys_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_hold();
    test_jump_wait();
    test_jump_rvalid_hold();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
